// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
//
// Shared definitions for the SRAM port arbiter:
//   - arbiter state encoding (IDLE / OWN0 / OWN1 / GAP)
//   - requester port indices (PORT_LOAD = load/store path, PORT_SPI = readout)
//   - SRAM read latency, measured from the requester's access cycle to the
//     cycle in which Q holds the read data
//   - read-tag record carried down the read-return pipe
//   - round-robin grant decision shared by IDLE and GAP
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] OWN0 = 2'b01;
    localparam logic [1:0] OWN1 = 2'b10;
    localparam logic [1:0] GAP  = 2'b11;

    localparam logic PORT_LOAD = 1'b0;
    localparam logic PORT_SPI  = 1'b1;

    localparam int RD_LATENCY = 2;

    typedef struct packed {
        logic vld;
        logic owner;
    } rd_tag_t;

    // Grant decision from an idle port. On a tie the port that did not own
    // the SRAM most recently wins.
    function automatic logic [1:0] arb_pick(input logic req0,
                                            input logic req1,
                                            input logic last_owner);
        if (req0 && req1) begin
            return (last_owner == PORT_LOAD) ? OWN1 : OWN0;
        end else if (req0) begin
            return OWN0;
        end else if (req1) begin
            return OWN1;
        end
        return IDLE;
    endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// ---------------------------------------------------------------------------
// sram_rd_tag_pipe
//
// Shift register of {valid, owner} tags that follows each SRAM read from the
// cycle it is issued to the cycle its data appears on Q. The tag output is
// decoded into one read-valid strobe per requester, so data keeps returning
// to the port that issued the read even after ownership has moved on.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset; drops in-flight tags
//   push        in   a read is being handed to the SRAM drive registers
//   push_owner  in   port that issued the read (PORT_LOAD / PORT_SPI)
//   rvld0       out  Q carries read data for port 0 this cycle
//   rvld1       out  Q carries read data for port 1 this cycle
// ---------------------------------------------------------------------------
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_owner,
    output logic rvld0,
    output logic rvld1
);

    rd_tag_t [RD_LATENCY-1:0] tag_p;

    // Stage 0 lines up with the registered SRAM access, the last stage lines
    // up with valid Q data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_p <= '0;
        end else begin
            tag_p[0] <= '{vld: push, owner: push_owner};
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_p[i] <= tag_p[i-1];
            end
        end
    end

    assign rvld0 = tag_p[RD_LATENCY-1].vld && (tag_p[RD_LATENCY-1].owner == PORT_LOAD);
    assign rvld1 = tag_p[RD_LATENCY-1].vld && (tag_p[RD_LATENCY-1].owner == PORT_SPI);

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares the single RA1SHD 512x8 SRAM port between the SRAM_IO_CTRL
// load/store path (port 0) and the PSEUDO_SPI readout path (port 1) using a
// req/gnt handshake with round-robin tie breaking. The owner's access is
// registered onto the SRAM pins, reads are tagged so their data returns with
// the issuing port's RVLD, and a hold watchdog revokes an owner that keeps
// the port for MAX_HOLD cycles while the other port is waiting.
//
// Ports:
//   CLK          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   REQ0/REQ1    in   ownership request, held for the whole burst
//   CEN0/CEN1    in   chip enable (active-low), used only while granted
//   WE0/WE1      in   1 = write, 0 = read
//   A0/A1        in   address
//   D0/D1        in   write data
//   GNT0/GNT1    out  port owns the SRAM (registered)
//   RVLD0/RVLD1  out  Q_OUT holds read data for that port this cycle
//   Q_OUT        out  SRAM Q passed straight through to both ports
//   Q_IN         in   SRAM Q
//   SRAM_CEN     out  SRAM CEN (registered, idles at 1)
//   SRAM_WEN     out  SRAM WEN (registered, 1 = write)
//   SRAM_A       out  SRAM address (registered)
//   SRAM_D       out  SRAM write data (registered)
//   BUSY         out  arbiter is not idle
//   TIMEOUT_ERR  out  sticky: an owner has been revoked
//   ERR_CLR      in   synchronous clear of TIMEOUT_ERR (a new revoke wins)
// ---------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_HOLD       = 256,
    parameter int HOLD_CNT_WIDTH = 9
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic                  CEN0,
    input  logic                  CEN1,
    input  logic                  WE0,
    input  logic                  WE1,
    input  logic [ADDR_WIDTH-1:0] A0,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [DATA_WIDTH-1:0] D0,
    input  logic [DATA_WIDTH-1:0] D1,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  RVLD0,
    output logic                  RVLD1,
    output logic [DATA_WIDTH-1:0] Q_OUT,
    input  logic [DATA_WIDTH-1:0] Q_IN,
    output logic                  SRAM_CEN,
    output logic                  SRAM_WEN,
    output logic [ADDR_WIDTH-1:0] SRAM_A,
    output logic [DATA_WIDTH-1:0] SRAM_D,
    output logic                  BUSY,
    output logic                  TIMEOUT_ERR,
    input  logic                  ERR_CLR
);

    localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST = HOLD_CNT_WIDTH'(MAX_HOLD - 1);

    logic [1:0]                state;
    logic [1:0]                state_nxt;
    logic                      last_owner;
    logic [HOLD_CNT_WIDTH-1:0] hold_cnt;

    // Set when a port is revoked; that port is ignored until it lowers REQ.
    logic                      blk0;
    logic                      blk1;

    logic req0_eff;
    logic req1_eff;
    logic own0;
    logic own1;
    logic hold_max;
    logic revoke0;
    logic revoke1;
    logic exit0;
    logic exit1;
    logic drive0;
    logic drive1;
    logic rd_push;
    logic rd_owner;

    // Saturating increment of the hold counter.
    function automatic logic [HOLD_CNT_WIDTH-1:0] hold_inc_sat(
        input logic [HOLD_CNT_WIDTH-1:0] cnt);
        if (cnt == HOLD_LAST) begin
            return cnt;
        end
        return cnt + HOLD_CNT_WIDTH'(1);
    endfunction

    assign req0_eff = REQ0 && !blk0;
    assign req1_eff = REQ1 && !blk1;

    assign own0     = (state == OWN0);
    assign own1     = (state == OWN1);
    assign hold_max = (hold_cnt == HOLD_LAST);

    // Revoke only when the other port actually wants the SRAM.
    assign revoke0 = own0 && REQ0 && hold_max && req1_eff;
    assign revoke1 = own1 && REQ1 && hold_max && req0_eff;

    assign exit0 = own0 && (!REQ0 || revoke0);
    assign exit1 = own1 && (!REQ1 || revoke1);

    // The leaving owner's last cycle is not forwarded, so the GAP cycle
    // always presents an idle SRAM.
    assign drive0 = own0 && !exit0;
    assign drive1 = own1 && !exit1;

    assign rd_push  = (drive0 && !CEN0 && !WE0) || (drive1 && !CEN1 && !WE1);
    assign rd_owner = drive1 ? PORT_SPI : PORT_LOAD;

    assign BUSY  = (state != IDLE);
    assign Q_OUT = Q_IN;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = arb_pick(req0_eff, req1_eff, last_owner);
            OWN0:    if (exit0) state_nxt = GAP;
            OWN1:    if (exit1) state_nxt = GAP;
            GAP:     state_nxt = arb_pick(req0_eff, req1_eff, last_owner);
        endcase
    end

    // ---- control stage: state, grants, hold watchdog, error flag ----
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            GNT0        <= 1'b0;
            GNT1        <= 1'b0;
            last_owner  <= PORT_SPI;
            hold_cnt    <= '0;
            TIMEOUT_ERR <= 1'b0;
            blk0        <= 1'b0;
            blk1        <= 1'b0;
        end else begin
            state <= state_nxt;
            GNT0  <= (state_nxt == OWN0);
            GNT1  <= (state_nxt == OWN1);

            // Updated on the way into GAP so the GAP decision already sees
            // the port that just released.
            if (exit0) begin
                last_owner <= PORT_LOAD;
            end else if (exit1) begin
                last_owner <= PORT_SPI;
            end

            if (state_nxt != state) begin
                hold_cnt <= '0;
            end else if (own0 || own1) begin
                hold_cnt <= hold_inc_sat(hold_cnt);
            end

            if (revoke0 || revoke1) begin
                TIMEOUT_ERR <= 1'b1;
            end else if (ERR_CLR) begin
                TIMEOUT_ERR <= 1'b0;
            end

            if (revoke0) begin
                blk0 <= 1'b1;
            end else if (!REQ0) begin
                blk0 <= 1'b0;
            end

            if (revoke1) begin
                blk1 <= 1'b1;
            end else if (!REQ1) begin
                blk1 <= 1'b0;
            end
        end
    end

    // ---- SRAM drive stage: owner's access appears on the pins one cycle later ----
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            SRAM_CEN <= 1'b1;
            SRAM_WEN <= 1'b0;
            SRAM_A   <= '0;
            SRAM_D   <= '0;
        end else if (drive0) begin
            SRAM_CEN <= CEN0;
            SRAM_WEN <= WE0;
            SRAM_A   <= A0;
            SRAM_D   <= D0;
        end else if (drive1) begin
            SRAM_CEN <= CEN1;
            SRAM_WEN <= WE1;
            SRAM_A   <= A1;
            SRAM_D   <= D1;
        end else begin
            SRAM_CEN <= 1'b1;
        end
    end

    // ---- read return stage: tags line up with Q_IN ----
    sram_rd_tag_pipe u_rd_tag_pipe (
        .clk        (CLK),
        .rst_n      (rst_n),
        .push       (rd_push),
        .push_owner (rd_owner),
        .rvld0      (RVLD0),
        .rvld1      (RVLD1)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          REQ0, REQ1, CEN0, CEN1, WE0, WE1;
    logic [AW-1:0] A0, A1;
    logic [DW-1:0] D0, D1;
    logic          GNT0, GNT1, RVLD0, RVLD1;
    logic [DW-1:0] Q_OUT, Q_IN;
    logic          SRAM_CEN, SRAM_WEN;
    logic [AW-1:0] SRAM_A;
    logic [DW-1:0] SRAM_D;
    logic          BUSY, TIMEOUT_ERR, ERR_CLR;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    logic [DW-1:0] wdata [4] = '{8'h2A, 8'h3C, 8'h05, 8'h9E};

    always #5 CLK = ~CLK;

    sram_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_HOLD       (8),
        .HOLD_CNT_WIDTH (4)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .REQ0        (REQ0),
        .REQ1        (REQ1),
        .CEN0        (CEN0),
        .CEN1        (CEN1),
        .WE0         (WE0),
        .WE1         (WE1),
        .A0          (A0),
        .A1          (A1),
        .D0          (D0),
        .D1          (D1),
        .GNT0        (GNT0),
        .GNT1        (GNT1),
        .RVLD0       (RVLD0),
        .RVLD1       (RVLD1),
        .Q_OUT       (Q_OUT),
        .Q_IN        (Q_IN),
        .SRAM_CEN    (SRAM_CEN),
        .SRAM_WEN    (SRAM_WEN),
        .SRAM_A      (SRAM_A),
        .SRAM_D      (SRAM_D),
        .BUSY        (BUSY),
        .TIMEOUT_ERR (TIMEOUT_ERR),
        .ERR_CLR     (ERR_CLR)
    );

    // Synchronous SRAM: access registered at the clock edge, Q valid after it.
    logic [DW-1:0] mem [512];
    logic [DW-1:0] sram_q = '0;
    always @(posedge CLK) begin
        if (!SRAM_CEN) begin
            if (SRAM_WEN) mem[SRAM_A] <= SRAM_D;
            else          sram_q      <= mem[SRAM_A];
        end
    end
    assign Q_IN = sram_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sb_push(input logic port, input logic [DW-1:0] data);
        sb.push_back('{port: port, data: data});
    endtask

    // Read-return monitor: every RVLD must match the oldest expected read.
    always @(negedge CLK) begin
        if (RVLD0 || RVLD1) begin
            if (RVLD0 && RVLD1) begin
                chk("rvld_both", {RVLD0, RVLD1}, 2'b00);
            end else if (sb.size() == 0) begin
                chk("rvld_unexpected", {RVLD0, RVLD1}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rvld_port", {31'd0, RVLD1}, {31'd0, e.port});
                chk("q_out", {24'd0, Q_OUT}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n = 1'b0; REQ0 = 0; REQ1 = 0; CEN0 = 1; CEN1 = 1; WE0 = 0; WE1 = 0;
        A0 = '0; A1 = '0; D0 = '0; D1 = '0; ERR_CLR = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_gnt0", GNT0, 0);
        chk("rst_gnt1", GNT1, 0);
        chk("rst_rvld", {RVLD0, RVLD1}, 0);
        chk("rst_sram_cen", SRAM_CEN, 1);
        chk("rst_sram_wen", SRAM_WEN, 0);
        chk("rst_sram_a", SRAM_A, 0);
        chk("rst_sram_d", SRAM_D, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_terr", TIMEOUT_ERR, 0);
        rst_n = 1'b1;

        // Port 0 alone: 4 writes then 4 reads.
        REQ0 = 1;
        tick();
        chk("t1_gnt0_latency", GNT0, 1);
        chk("t1_gnt1", GNT1, 0);
        chk("t1_busy", BUSY, 1);
        for (int i = 0; i < 4; i++) begin
            CEN0 = 0; WE0 = 1; A0 = AW'(9'h020 + i); D0 = wdata[i];
            tick();
            chk("t1_wr_sram_a", SRAM_A, 9'h020 + i);
            chk("t1_wr_sram_cen", SRAM_CEN, 0);
            chk("t1_wr_sram_wen", SRAM_WEN, 1);
            chk("t1_wr_sram_d", SRAM_D, wdata[i]);
        end
        for (int i = 0; i < 4; i++) begin
            CEN0 = 0; WE0 = 0; A0 = AW'(9'h020 + i);
            sb_push(1'b0, wdata[i]);
            tick();
            chk("t1_rd_sram_a", SRAM_A, 9'h020 + i);
            chk("t1_rd_sram_wen", SRAM_WEN, 0);
            chk("t1_rvld0_timing", RVLD0, (i >= 1) ? 1 : 0);
        end
        CEN0 = 1;
        tick();
        chk("t1_rvld0_last", RVLD0, 1);
        tick();
        chk("t1_rvld0_end", RVLD0, 0);
        REQ0 = 0;
        tick();
        chk("t1_gap_gnt0", GNT0, 0);
        chk("t1_gap_cen", SRAM_CEN, 1);
        chk("t1_gap_busy", BUSY, 1);
        tick();
        chk("t1_idle_busy", BUSY, 0);

        // Simultaneous requests from reset: port 0 first.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        REQ0 = 1; REQ1 = 1;
        tick();
        chk("t2_gnt0", GNT0, 1);
        chk("t2_gnt1", GNT1, 0);
        tick();
        REQ0 = 0;
        tick();
        chk("t2_gap_gnts", {GNT0, GNT1}, 2'b00);
        chk("t2_gap_cen", SRAM_CEN, 1);
        tick();
        chk("t2_gnt1_after_gap", GNT1, 1);

        // Port 1 reads in its last cycle, then releases while port 0 waits.
        REQ0 = 1; CEN1 = 0; WE1 = 0; A1 = 9'h022;
        sb_push(1'b1, 8'h05);
        tick();
        chk("t5_gnt1_still", GNT1, 1);
        REQ1 = 0; CEN1 = 1;
        tick();
        chk("t5_rvld1", RVLD1, 1);
        chk("t5_rvld0", RVLD0, 0);
        chk("t5_gap_gnts", {GNT0, GNT1}, 2'b00);
        tick();
        chk("t5_gnt0", GNT0, 1);
        chk("t5_rvld1_done", RVLD1, 0);

        // Tie with last_owner = 0: port 1 wins.
        REQ0 = 0;
        tick();
        tick();
        chk("t3_idle", BUSY, 0);
        REQ0 = 1; REQ1 = 1;
        tick();
        chk("t3_gnt1", GNT1, 1);
        chk("t3_gnt0", GNT0, 0);
        REQ0 = 0; REQ1 = 0;
        tick();
        tick();

        // Hold watchdog with MAX_HOLD = 8.
        REQ0 = 1;
        tick();
        chk("t4_gnt0", GNT0, 1);
        tick();
        REQ1 = 1;
        for (int k = 3; k <= 8; k++) begin
            tick();
            chk("t4_gnt0_hold", GNT0, 1);
            chk("t4_terr_low", TIMEOUT_ERR, 0);
        end
        tick();
        chk("t4_revoke_gnts", {GNT0, GNT1}, 2'b00);
        chk("t4_terr_set", TIMEOUT_ERR, 1);
        chk("t4_gap_cen", SRAM_CEN, 1);
        tick();
        chk("t4_gnt1", GNT1, 1);
        chk("t4_gnt0_off", GNT0, 0);
        tick();
        tick();
        chk("t4_terr_sticky", TIMEOUT_ERR, 1);
        REQ1 = 0;
        tick();
        tick();
        chk("t4_no_regrant", GNT0, 0);
        chk("t4_idle", BUSY, 0);
        tick();
        chk("t4_no_regrant2", GNT0, 0);
        ERR_CLR = 1;
        tick();
        ERR_CLR = 0;
        chk("t4_terr_clr", TIMEOUT_ERR, 0);
        REQ0 = 0;
        tick();
        REQ0 = 1;
        tick();
        chk("t4_regrant", GNT0, 1);

        // Reset in the middle of a read.
        CEN0 = 0; WE0 = 0; A0 = 9'h021;
        tick();
        chk("t6_cen_active", SRAM_CEN, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_gnt0", GNT0, 0);
        chk("t6_cen", SRAM_CEN, 1);
        chk("t6_sram_a", SRAM_A, 0);
        chk("t6_busy", BUSY, 0);
        chk("t6_rvld", {RVLD0, RVLD1}, 0);
        REQ0 = 0; CEN0 = 1;
        tick();
        tick();
        rst_n = 1'b1;
        REQ1 = 1;
        tick();
        chk("t6_gnt1", GNT1, 1);
        tick();
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
